pong_ball_engine: RTL
=====================

// Module: pong_ball_engine
// PURPOSE
//  Pixel source feeding the sync/blanking stage: consumes its hc/vc counters, owns ball motion,
//  paddle/wall bounces, serve timing and miss detection, and produces registered rgb for its inputs.
//  Motion updates once per frame in vertical blanking, so a frame never tears.
// PARAMETERS
//  HACTIVE       640  visible pixels per line
//  VACTIVE       480  visible lines per frame
//  BALL_SIZE     8    ball edge, pixels (square)
//  BALL_SPEED    2    pixels per frame moved on each axis
//  PADDLE_W      8    paddle width, pixels
//  PADDLE_H      64   paddle height, pixels
//  PADDLE_LX     32   left paddle left edge x
//  PADDLE_RX     600  right paddle left edge x
//  SERVE_FRAMES  60   frames the ball rests at centre before moving
// PORTS
//  clk      in   1   pixel clock, same clock as the sync stage
//  rst_n    in   1   synchronous reset, active low
//  hc       in   11  horizontal counter from sync stage
//  vc       in   11  vertical counter from sync stage
//  pad_l_y  in   11  left paddle top y
//  pad_r_y  in   11  right paddle top y
//  rout     out  8   red to sync stage rin
//  gout     out  8   green to sync stage gin
//  bout     out  8   blue to sync stage bin
//  score_l  out  1   one-clock pulse: left player scored (ball exited right)
//  score_r  out  1   one-clock pulse: right player scored (ball exited left)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): ball_x=(HACTIVE-BALL_SIZE)/2=316, ball_y=(VACTIVE-BALL_SIZE)/2=236,
//    dir_x=right, dir_y=down, state=SERVE, serve_cnt=0, rgb=0, score_l=score_r=0. Applies mid-frame too.
//  - tick = (hc==0 && vc==VACTIVE): exactly one clock per frame. All motion/state changes occur only on tick;
//    SCORED->SERVE is the sole exception (next clock).
//  - Paddle y sampled on tick, clamped to VACTIVE-PADDLE_H (416) if larger.
//  - FSM: SERVE -tick, serve_cnt==SERVE_FRAMES-1-> PLAY (no move on that tick; else serve_cnt++).
//    PLAY -tick, miss-> SCORED. SCORED -1 clk-> SERVE: ball recentred, serve_cnt=0, dir_x toward conceding
//    side, dir_y unchanged.
//  - PLAY tick arithmetic, 12-bit unsigned to avoid wrap; vertical and horizontal resolved independently, same tick:
//    down: if y+SPEED+BALL_SIZE>=VACTIVE then y=VACTIVE-BALL_SIZE, dir_y=up; else y+=SPEED.
//    up: if y<SPEED then y=0, dir_y=down; else y-=SPEED.
//    left: face=PADDLE_LX+PADDLE_W (40). If x>=face && x-SPEED<face && overlap_l then x=face, dir_x=right;
//      else if x<SPEED -> miss, score_r; else x-=SPEED.
//    right: face=PADDLE_RX-BALL_SIZE (592). If x<=face && x+SPEED>face && overlap_r then x=face, dir_x=left;
//      else if x+SPEED+BALL_SIZE>HACTIVE -> miss, score_l; else x+=SPEED.
//    overlap = (ball_y+BALL_SIZE > pad_y) && (ball_y < pad_y+PADDLE_H), using pre-move ball_y.
//  - score_l/score_r registered, high exactly the one clock the FSM is in SCORED; never both.
//  - Pixel path, latency 1 clock (rgb at clk N+1 describes hc/vc at clk N), priority:
//    outside hc<HACTIVE && vc<VACTIVE -> 000000; ball box -> FFFFFF; either paddle box -> FFFFFF;
//    net (hc==HACTIVE/2-1 or HACTIVE/2, vc[3]==0) -> 808080; else 000000.
//  - Ball drawn in SERVE, PLAY and SCORED using current registers.
// TESTING
//  1 Reset, run 61 frames, pads at 0: ball holds 316,236 for frames 1..60, then x=318,y=238 after next tick.
//  2 Ball at y=470 moving down, tick -> y=472, dir_y=up; next tick y=470.
//  3 Ball x=41 left, pad_l_y=200, ball_y=230, tick -> x=40, dir_x=right, no score pulse.
//  4 Same with pad_l_y=300: ticks until x<2, then score_r high exactly 1 clk, ball 316,236, dir_x=left, SERVE.
//  5 Pixel: ball at 100,100: hc=100,vc=100 -> rgb FFFFFF next clk; hc=320,vc=4 -> 808080;
//    hc=320,vc=8 -> 000000; hc=700 -> 000000.
//  6 rst_n low for 1 clk mid-PLAY and mid-line: next clk outputs 0, state SERVE, ball 316,236; pad_l_y=470 draws at 416.

Source files
------------

// File: rtl/pong_ball_engine.sv
// pong_ball_engine
//   Pixel source for the sync/blanking stage. Owns ball motion, paddle and wall
//   bounces, serve timing and miss detection. Ball and paddle state change only
//   on the single per-frame tick (hc==0, vc==VACTIVE), so a visible frame never tears.
// Ports
//   clk, rst_n        pixel clock, synchronous active-low reset
//   hc, vc            pixel counters from the sync stage
//   pad_l_y, pad_r_y  paddle top rows; sampled and clamped on tick
//   rout/gout/bout    registered colour, one clock behind hc/vc
//   score_l, score_r  one-clock pulse while the FSM sits in SCORED
module pong_ball_engine #(
  parameter int HACTIVE      = 640,
  parameter int VACTIVE      = 480,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_LX    = 32,
  parameter int PADDLE_RX    = 600,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic [10:0] pad_l_y,
  input  logic [10:0] pad_r_y,
  output logic [7:0]  rout,
  output logic [7:0]  gout,
  output logic [7:0]  bout,
  output logic        score_l,
  output logic        score_r
);
  // 12-bit working width keeps x+SPEED+SIZE and pad+PADDLE_H from wrapping.
  localparam logic [11:0] L_HA     = 12'(HACTIVE);
  localparam logic [11:0] L_VA     = 12'(VACTIVE);
  localparam logic [11:0] L_BS     = 12'(BALL_SIZE);
  localparam logic [11:0] L_SP     = 12'(BALL_SPEED);
  localparam logic [11:0] L_PW     = 12'(PADDLE_W);
  localparam logic [11:0] L_PH     = 12'(PADDLE_H);
  localparam logic [11:0] L_LX     = 12'(PADDLE_LX);
  localparam logic [11:0] L_RX     = 12'(PADDLE_RX);
  localparam logic [11:0] L_CX     = 12'((HACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] L_CY     = 12'((VACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] L_YMAX   = 12'(VACTIVE - BALL_SIZE);
  localparam logic [11:0] L_PMAX   = 12'(VACTIVE - PADDLE_H);
  localparam logic [11:0] L_FACE_L = 12'(PADDLE_LX + PADDLE_W);
  localparam logic [11:0] L_FACE_R = 12'(PADDLE_RX - BALL_SIZE);
  localparam logic [11:0] L_NET0   = 12'(HACTIVE / 2 - 1);
  localparam logic [11:0] L_NET1   = 12'(HACTIVE / 2);
  localparam int          CW       = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] L_SLAST = CW'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_SCORED} state_t;

  state_t        r_state, w_state_nxt;
  logic [11:0]   r_bx, r_by, r_pl, r_pr;
  logic          r_dx_left, r_dy_up;
  logic [CW-1:0] r_serve_cnt;
  logic [23:0]   r_rgb;
  logic          r_score_l, r_score_r;

  logic [11:0] w_hc, w_vc, w_pl_c, w_pr_c, w_bx_nxt, w_by_nxt;
  logic        w_tick, w_ovl_l, w_ovl_r, w_dx_nxt, w_dy_nxt, w_miss_l, w_miss_r;
  logic        w_serve_tick, w_play_tick, w_recentre;
  logic        w_active, w_in_ball, w_in_pad, w_in_net;
  logic [23:0] w_rgb;

  assign w_hc   = {1'b0, hc};
  assign w_vc   = {1'b0, vc};
  assign w_tick = (w_hc == 12'd0) && (w_vc == L_VA);
  assign w_pl_c = ({1'b0, pad_l_y} > L_PMAX) ? L_PMAX : {1'b0, pad_l_y};
  assign w_pr_c = ({1'b0, pad_r_y} > L_PMAX) ? L_PMAX : {1'b0, pad_r_y};

  // Collision uses the paddle value being sampled on this tick and the pre-move ball y.
  assign w_ovl_l = (r_by + L_BS > w_pl_c) && (r_by < w_pl_c + L_PH);
  assign w_ovl_r = (r_by + L_BS > w_pr_c) && (r_by < w_pr_c + L_PH);

  always_comb begin
    w_by_nxt = r_by;
    w_dy_nxt = r_dy_up;
    if (r_dy_up) begin
      if (r_by < L_SP) begin
        w_by_nxt = '0;
        w_dy_nxt = 1'b0;
      end else begin
        w_by_nxt = r_by - L_SP;
      end
    end else if (r_by + L_SP + L_BS >= L_VA) begin
      w_by_nxt = L_YMAX;
      w_dy_nxt = 1'b1;
    end else begin
      w_by_nxt = r_by + L_SP;
    end
  end

  // A miss leaves x where it was; the ball is recentred on leaving SCORED.
  always_comb begin
    w_bx_nxt = r_bx;
    w_dx_nxt = r_dx_left;
    w_miss_l = 1'b0;
    w_miss_r = 1'b0;
    if (r_dx_left) begin
      if ((r_bx >= L_FACE_L) && (r_bx - L_SP < L_FACE_L) && w_ovl_l) begin
        w_bx_nxt = L_FACE_L;
        w_dx_nxt = 1'b0;
      end else if (r_bx < L_SP) begin
        w_miss_l = 1'b1;
      end else begin
        w_bx_nxt = r_bx - L_SP;
      end
    end else begin
      if ((r_bx <= L_FACE_R) && (r_bx + L_SP > L_FACE_R) && w_ovl_r) begin
        w_bx_nxt = L_FACE_R;
        w_dx_nxt = 1'b1;
      end else if (r_bx + L_SP + L_BS > L_HA) begin
        w_miss_r = 1'b1;
      end else begin
        w_bx_nxt = r_bx + L_SP;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_SERVE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SERVE:  if (w_tick && (r_serve_cnt == L_SLAST)) w_state_nxt = S_PLAY;
      S_PLAY:   if (w_tick && (w_miss_l || w_miss_r))   w_state_nxt = S_SCORED;
      S_SCORED: w_state_nxt = S_SERVE;
      default:  w_state_nxt = S_SERVE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_serve_tick = (r_state == S_SERVE) && w_tick;
    w_play_tick  = (r_state == S_PLAY) && w_tick;
    w_recentre   = (r_state == S_SCORED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bx        <= L_CX;
      r_by        <= L_CY;
      r_dx_left   <= 1'b0;
      r_dy_up     <= 1'b0;
      r_serve_cnt <= '0;
      r_pl        <= '0;
      r_pr        <= '0;
    end else if (w_recentre) begin
      // Serve toward the side that conceded: right scored means ball left via the left.
      r_bx        <= L_CX;
      r_by        <= L_CY;
      r_dx_left   <= r_score_r;
      r_serve_cnt <= '0;
    end else if (w_tick) begin
      r_pl <= w_pl_c;
      r_pr <= w_pr_c;
      if (w_serve_tick && (r_serve_cnt != L_SLAST)) r_serve_cnt <= r_serve_cnt + 1'b1;
      if (w_play_tick) begin
        r_bx      <= w_bx_nxt;
        r_by      <= w_by_nxt;
        r_dx_left <= w_dx_nxt;
        r_dy_up   <= w_dy_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_score_l <= w_play_tick && w_miss_r;
      r_score_r <= w_play_tick && w_miss_l;
    end
  end

  assign w_active  = (w_hc < L_HA) && (w_vc < L_VA);
  assign w_in_ball = (w_hc >= r_bx) && (w_hc < r_bx + L_BS) && (w_vc >= r_by) && (w_vc < r_by + L_BS);
  assign w_in_pad  = ((w_hc >= L_LX) && (w_hc < L_LX + L_PW) && (w_vc >= r_pl) && (w_vc < r_pl + L_PH)) ||
                     ((w_hc >= L_RX) && (w_hc < L_RX + L_PW) && (w_vc >= r_pr) && (w_vc < r_pr + L_PH));
  assign w_in_net  = ((w_hc == L_NET0) || (w_hc == L_NET1)) && !vc[3];

  always_comb begin
    w_rgb = 24'h000000;
    if (!w_active)                 w_rgb = 24'h000000;
    else if (w_in_ball || w_in_pad) w_rgb = 24'hFFFFFF;
    else if (w_in_net)             w_rgb = 24'h808080;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_rgb <= '0;
    else        r_rgb <= w_rgb;
  end

  assign {rout, gout, bout} = r_rgb;
  assign score_l = r_score_l;
  assign score_r = r_score_r;
endmodule
